// File: rtl/cjb_lsu_pkg.sv
// Shared definitions for the logic/shift unit: operation codes, FSM states and flag bit positions.
package cjb_lsu_pkg;

  localparam logic [2:0] FS_XOR  = 3'b000;
  localparam logic [2:0] FS_AND  = 3'b001;
  localparam logic [2:0] FS_OR   = 3'b010;
  localparam logic [2:0] FS_PASS = 3'b011;
  localparam logic [2:0] FS_NOT  = 3'b100;
  localparam logic [2:0] FS_SHL  = 3'b101;
  localparam logic [2:0] FS_SHR  = 3'b110;
  localparam logic [2:0] FS_ROR  = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } lsu_state_e;

  localparam int FLG_C = 3;
  localparam int FLG_N = 2;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 0;

  function automatic logic is_shift_op(input logic [2:0] func);
    return (func == FS_SHL) || (func == FS_SHR) || (func == FS_ROR);
  endfunction

endpackage

// File: rtl/cjb_lsu_shifter.sv
// Combinational shifter returning {carry_out, data}: a single-position step by default,
// or a full barrel shifter when CJB_LSU_FAST_SHIFT_EN is defined.
module cjb_lsu_shifter
  import cjb_lsu_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef CJB_LSU_FAST_SHIFT_EN
  , parameter int SHAMT_W = 3
`endif
) (
  input  logic [2:0]         op_i,
  input  logic [WIDTH-1:0]   data_i,
`ifdef CJB_LSU_FAST_SHIFT_EN
  input  logic [SHAMT_W-1:0] amount_i,
`endif
  output logic [WIDTH:0]     result_o
);

`ifdef CJB_LSU_FAST_SHIFT_EN
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH-1:0] ror_data;
  logic [31:0]      rot_amt;

  // The spare bit on each extended vector catches the last bit shifted out, which
  // matches the serial carry even when the amount reaches or exceeds WIDTH.
  always_comb begin
    shl_ext  = {1'b0, data_i} << amount_i;
    shr_ext  = {data_i, 1'b0} >> amount_i;
    rot_amt  = 32'(amount_i) % 32'(WIDTH);
    ror_data = (data_i >> rot_amt) | (data_i << (32'(WIDTH) - rot_amt));
    result_o = {1'b0, data_i};
    case (op_i)
      FS_SHL:  result_o = shl_ext;
      FS_SHR:  result_o = {shr_ext[0], shr_ext[WIDTH:1]};
      FS_ROR:  result_o = {(amount_i != '0) & ror_data[WIDTH-1], ror_data};
      default: result_o = {1'b0, data_i};
    endcase
  end
`else
  // One position per call; for ROR the carry is the bit that wraps into the MSB.
  always_comb begin
    result_o = {1'b0, data_i};
    case (op_i)
      FS_SHL:  result_o = {data_i, 1'b0};
      FS_SHR:  result_o = {data_i[0], 1'b0, data_i[WIDTH-1:1]};
      FS_ROR:  result_o = {data_i[0], data_i[0], data_i[WIDTH-1:1]};
      default: result_o = {1'b0, data_i};
    endcase
  end
`endif

endmodule

// File: rtl/cjb_logic_shift_unit.sv
// Registered logic/shift unit with Start/Busy/Done handshake and CNVZ flags.
// Define CJB_LSU_FAST_SHIFT_EN for single-cycle barrel shifts instead of the serial FSM.
module cjb_logic_shift_unit
  import cjb_lsu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [2:0]         Func_Sel,
  input  logic [WIDTH-1:0]   Operand_X,
  input  logic [WIDTH-1:0]   Operand_Y,
  input  logic [SHAMT_W-1:0] Const_K,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Logic_Result,
  output logic [3:0]         Logic_CNVZ
);

  lsu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       cnvz_q, cnvz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] logic_res;
  logic [WIDTH:0]   shift_out;

`ifndef CJB_LSU_FAST_SHIFT_EN
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [2:0]         func_q, func_d;
`endif

  function automatic logic [3:0] make_flags(input logic carry, input logic [WIDTH-1:0] value);
    logic [3:0] flags;
    flags        = 4'b0000;
    flags[FLG_C] = carry;
    flags[FLG_N] = value[WIDTH-1];
    flags[FLG_V] = 1'b0;
    flags[FLG_Z] = (value == '0);
    return flags;
  endfunction

  always_comb begin
    logic_res = Operand_X;
    case (Func_Sel)
      FS_XOR:  logic_res = Operand_X ^ Operand_Y;
      FS_AND:  logic_res = Operand_X & Operand_Y;
      FS_OR:   logic_res = Operand_X | Operand_Y;
      FS_NOT:  logic_res = ~Operand_X;
      default: logic_res = Operand_X;
    endcase
  end

`ifdef CJB_LSU_FAST_SHIFT_EN
  cjb_lsu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .op_i     (Func_Sel),
    .data_i   (Operand_X),
    .amount_i (Const_K),
    .result_o (shift_out)
  );
`else
  cjb_lsu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .op_i     (func_q),
    .data_i   (work_q),
    .result_o (shift_out)
  );
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    cnvz_d   = cnvz_q;
    done_d   = 1'b0;
`ifndef CJB_LSU_FAST_SHIFT_EN
    count_d  = count_q;
    work_d   = work_q;
    func_d   = func_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
`ifdef CJB_LSU_FAST_SHIFT_EN
          if (is_shift_op(Func_Sel)) begin
            result_d = shift_out[WIDTH-1:0];
            cnvz_d   = make_flags(shift_out[WIDTH], shift_out[WIDTH-1:0]);
          end else begin
            result_d = logic_res;
            cnvz_d   = make_flags(1'b0, logic_res);
          end
          done_d = 1'b1;
`else
          if (is_shift_op(Func_Sel) && (Const_K != '0)) begin
            work_d  = Operand_X;
            count_d = Const_K;
            func_d  = Func_Sel;
            state_d = ST_SHIFT;
          end else begin
            // A zero-length shift returns the operand untouched, so it shares the logic path.
            result_d = is_shift_op(Func_Sel) ? Operand_X : logic_res;
            cnvz_d   = make_flags(1'b0, result_d);
            done_d   = 1'b1;
          end
`endif
        end
      end
      ST_SHIFT: begin
`ifdef CJB_LSU_FAST_SHIFT_EN
        state_d = ST_IDLE;
`else
        work_d  = shift_out[WIDTH-1:0];
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          result_d = shift_out[WIDTH-1:0];
          cnvz_d   = make_flags(shift_out[WIDTH], shift_out[WIDTH-1:0]);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      cnvz_q   <= 4'b0000;
      done_q   <= 1'b0;
`ifndef CJB_LSU_FAST_SHIFT_EN
      count_q  <= '0;
      work_q   <= '0;
      func_q   <= FS_XOR;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      cnvz_q   <= cnvz_d;
      done_q   <= done_d;
`ifndef CJB_LSU_FAST_SHIFT_EN
      count_q  <= count_d;
      work_q   <= work_d;
      func_q   <= func_d;
`endif
    end
  end

`ifdef CJB_LSU_FAST_SHIFT_EN
  assign Busy = 1'b0;
`else
  assign Busy = (state_q == ST_SHIFT);
`endif
  assign Done         = done_q;
  assign Logic_Result = result_q;
  assign Logic_CNVZ   = cnvz_q;

endmodule

// File: tb/tb_cjb_logic_shift_unit.sv
// Self-checking bench for cjb_logic_shift_unit: a cycle-level reference model checked on every
// cycle, directed cases with hand-computed results, and a randomized soak.
module tb_cjb_logic_shift_unit;

   localparam int W  = 8;
   localparam int KW = 3;
`ifdef CJB_LSU_FAST_SHIFT_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [2:0]    funcSel;
   logic [W-1:0]  operandX;
   logic [W-1:0]  operandY;
   logic [KW-1:0] constK;
   logic          busy;
   logic          done;
   logic [W-1:0]  logicResult;
   logic [3:0]    logicCnvz;

   int assertCount = 0;
   int failCount   = 0;
   bit checkEn     = 1'b0;

   int           pendLeft = 0;
   logic [W:0]   pendOut;
   logic [W:0]   modelOut;
   logic [W-1:0] expResult;
   logic [3:0]   expCnvz;
   logic         expDone;
   logic         expBusy;

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   cjb_logic_shift_unit #(
      .WIDTH   (W),
      .SHAMT_W (KW)
   ) dut (
      .Clock        (clock),
      .Reset        (reset),
      .Start        (start),
      .Func_Sel     (funcSel),
      .Operand_X    (operandX),
      .Operand_Y    (operandY),
      .Const_K      (constK),
      .Busy         (busy),
      .Done         (done),
      .Logic_Result (logicResult),
      .Logic_CNVZ   (logicCnvz)
   );

   // Reference result {carry, data} straight from the operation definitions, using integer maths.
   function automatic logic [W:0] refOp(input logic [2:0] f, input logic [W-1:0] x,
                                        input logic [W-1:0] y, input logic [KW-1:0] k);
      int xi, yi, ki, r, c, mask;
      xi   = int'(x);
      yi   = int'(y);
      ki   = int'(k);
      mask = (1 << W) - 1;
      c    = 0;
      r    = 0;
      case (f)
         3'd0: r = xi ^ yi;
         3'd1: r = xi & yi;
         3'd2: r = xi | yi;
         3'd3: r = xi;
         3'd4: r = mask - xi;
         3'd5: begin
            r = (xi << ki) & mask;
            if (ki >= 1 && ki <= W) c = (xi >> (W - ki)) & 1;
         end
         3'd6: begin
            r = xi >> ki;
            if (ki >= 1 && ki <= W) c = (xi >> (ki - 1)) & 1;
         end
         default: begin
            r = xi;
            for (int i = 0; i < ki; i++) r = (r >> 1) + ((r & 1) << (W - 1));
            if (ki > 0) c = (r >> (W - 1)) & 1;
         end
      endcase
      return {c[0], r[W-1:0]};
   endfunction

   function automatic logic [3:0] refFlags(input logic [W:0] r);
      return {r[W], r[W-1], 1'b0, (r[W-1:0] == '0)};
   endfunction

   // Cycle-level model: tracks how many busy cycles remain and what the held outputs must be.
   always @(posedge clock) begin
      expDone = 1'b0;
      if (reset === 1'b1) begin
         pendLeft  = 0;
         expBusy   = 1'b0;
         expResult = '0;
         expCnvz   = 4'b0000;
      end else if (pendLeft > 0) begin
         pendLeft--;
         if (pendLeft == 0) begin
            expBusy   = 1'b0;
            expDone   = 1'b1;
            expResult = pendOut[W-1:0];
            expCnvz   = refFlags(pendOut);
         end
      end else if (start === 1'b1) begin
         modelOut = refOp(funcSel, operandX, operandY, constK);
         if (!FAST && funcSel >= 3'd5 && constK != '0) begin
            pendLeft = int'(constK);
            pendOut  = modelOut;
            expBusy  = 1'b1;
         end else begin
            expDone   = 1'b1;
            expResult = modelOut[W-1:0];
            expCnvz   = refFlags(modelOut);
         end
      end
   end

   task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkOutput();
      checkValue("model done", 32'(done), 32'(expDone));
      checkValue("model busy", 32'(busy), 32'(expBusy));
      checkValue("model result", 32'(logicResult), 32'(expResult));
      checkValue("model cnvz", 32'(logicCnvz), 32'(expCnvz));
   endtask

   // Compare DUT against the model mid-cycle, well away from the rising edge.
   always @(negedge clock) begin
      if (checkEn) checkOutput();
   end

   // Holds Start for one cycle, then scrambles the operands to show they were captured.
   task automatic applyStimulus(input logic [2:0] f, input logic [W-1:0] x,
                                input logic [W-1:0] y, input logic [KW-1:0] k);
      start    = 1'b1;
      funcSel  = f;
      operandX = x;
      operandY = y;
      constK   = k;
      @(posedge clock); #1;
      start    = 1'b0;
      funcSel  = 3'($urandom);
      operandX = W'($urandom);
      operandY = W'($urandom);
      constK   = KW'($urandom);
   endtask

   task automatic runOp(input string name, input logic [2:0] f, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [KW-1:0] k,
                        input logic [W-1:0] wantRes, input logic [3:0] wantFlags,
                        input int wantLat, input int wantBusy);
      int lat;
      int busyCnt;
      applyStimulus(f, x, y, k);
      lat     = 1;
      busyCnt = 0;
      while (done !== 1'b1 && lat <= 40) begin
         if (busy === 1'b1) busyCnt++;
         @(posedge clock); #1;
         lat++;
      end
      if (lat > 40) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL %s timeout: got no Done expected Done within 40 cycles", name);
      end else begin
         checkValue({name, " latency"}, 32'(lat), 32'(wantLat));
         checkValue({name, " busy cycles"}, 32'(busyCnt), 32'(wantBusy));
         checkValue({name, " result"}, 32'(logicResult), 32'(wantRes));
         checkValue({name, " cnvz"}, 32'(logicCnvz), 32'(wantFlags));
      end
   endtask

   // Main sequence: reset, directed cases, then randomized traffic.
   initial begin
      int doneSeen;
      int firstDone;
      reset    = 1'b1;
      start    = 1'b0;
      funcSel  = 3'd0;
      operandX = '0;
      operandY = '0;
      constK   = '0;
      @(posedge clock); #1;
      checkEn = 1'b1;
      checkValue("reset busy", 32'(busy), 32'd0);
      checkValue("reset done", 32'(done), 32'd0);
      checkValue("reset result", 32'(logicResult), 32'h00);
      checkValue("reset cnvz", 32'(logicCnvz), 32'h0);
      @(posedge clock); #1;
      reset = 1'b0;

      runOp("not", 3'd4, 8'h00, 8'h00, 3'd0, 8'hFF, 4'b0100, 1, 0);
      runOp("shl", 3'd5, 8'h81, 8'h00, 3'd3, 8'h08, 4'b0000, FAST ? 1 : 4, FAST ? 0 : 3);
      runOp("ror", 3'd7, 8'h01, 8'h00, 3'd1, 8'h80, 4'b1100, FAST ? 1 : 2, FAST ? 0 : 1);
      runOp("shr k0", 3'd6, 8'h03, 8'h00, 3'd0, 8'h03, 4'b0000, 1, 0);
      runOp("shr k7", 3'd6, 8'hC0, 8'h00, 3'd7, 8'h01, 4'b1000, FAST ? 1 : 8, FAST ? 0 : 7);
      runOp("or", 3'd2, 8'h80, 8'h01, 3'd0, 8'h81, 4'b0100, 1, 0);
      runOp("pass", 3'd3, 8'h00, 8'hFF, 3'd5, 8'h00, 4'b0001, 1, 0);

      // Back-to-back single-cycle ops: AND then XOR on consecutive cycles.
      start = 1'b1; funcSel = 3'd1; operandX = 8'hF0; operandY = 8'h3C; constK = '0;
      @(posedge clock); #1;
      funcSel = 3'd0; operandX = 8'hAA; operandY = 8'hAA;
      checkValue("b2b and done", 32'(done), 32'd1);
      checkValue("b2b and result", 32'(logicResult), 32'h30);
      checkValue("b2b and cnvz", 32'(logicCnvz), 32'h0);
      @(posedge clock); #1;
      start = 1'b0;
      checkValue("b2b xor done", 32'(done), 32'd1);
      checkValue("b2b xor result", 32'(logicResult), 32'h00);
      checkValue("b2b xor cnvz", 32'(logicCnvz), 32'h1);
      @(posedge clock); #1;
      checkValue("b2b idle done", 32'(done), 32'd0);

`ifndef CJB_LSU_FAST_SHIFT_EN
      // A Start during a K=5 shift must be dropped entirely.
      applyStimulus(3'd5, 8'h0F, 8'h00, 3'd5);
      @(posedge clock); #1;
      start = 1'b1; funcSel = 3'd0; operandX = 8'hFF; operandY = 8'h00;
      @(posedge clock); #1;
      start     = 1'b0;
      doneSeen  = 0;
      firstDone = 0;
      for (int cyc = 3; cyc <= 14; cyc++) begin
         if (done === 1'b1) begin
            doneSeen++;
            if (firstDone == 0) firstDone = cyc;
         end
         @(posedge clock); #1;
      end
      checkValue("busy start done count", 32'(doneSeen), 32'd1);
      checkValue("busy start latency", 32'(firstDone), 32'd6);
      checkValue("busy start result", 32'(logicResult), 32'hE0);
      checkValue("busy start cnvz", 32'(logicCnvz), 32'hC);
`endif

      // Reset two cycles into SHL 0x81 K=3 aborts the shift and clears the outputs.
      runOp("not again", 3'd4, 8'h00, 8'h00, 3'd0, 8'hFF, 4'b0100, 1, 0);
      applyStimulus(3'd5, 8'h81, 8'h00, 3'd3);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      checkValue("abort busy", 32'(busy), 32'd0);
      checkValue("abort result", 32'(logicResult), 32'h00);
      checkValue("abort cnvz", 32'(logicCnvz), 32'h0);
      doneSeen = 0;
      repeat (6) begin
         if (done === 1'b1) doneSeen++;
         @(posedge clock); #1;
      end
      checkValue("abort done count", 32'(doneSeen), 32'd0);

      // Randomized traffic, including Starts while busy and the occasional reset.
      repeat (3000) begin
         start    = ($urandom_range(0, 2) != 0);
         funcSel  = 3'($urandom);
         operandX = W'($urandom);
         operandY = W'($urandom);
         constK   = KW'($urandom);
         reset    = ($urandom_range(0, 199) == 0);
         @(posedge clock); #1;
      end
      start = 1'b0;
      reset = 1'b0;
      repeat (20) @(posedge clock);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
